// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: write-controller FSM encoding and requester port indices.
package fb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_e;

    localparam int unsigned PORT_DRAW = 0;
    localparam int unsigned PORT_HOST = 1;

endpackage

// File: rtl/fb_write_ctrl_if.sv
// Bus bundle between the two pixel requesters, the clear control and the frame-buffer write port.
interface fb_write_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;

    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;

    logic                  clr_start;
    logic [DATA_WIDTH-1:0] clr_value;
    logic                  clr_busy;
    logic                  clr_done;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        output clr_start, clr_value,
        input  clr_busy, clr_done,
        input  ram_we, ram_wr_addr, ram_wr_data
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        input  clr_start, clr_value,
        output clr_busy, clr_done,
        output ram_we, ram_wr_addr, ram_wr_data
    );

endinterface

// File: rtl/fb_write_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; a tie goes to the port not granted most recently.
module rr_arb2
    import fb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    // Port that wins the next tie
    logic prio_q, prio_d;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                grant[prio_q] = 1'b1;
            end else begin
                grant = req;
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (grant[PORT_DRAW]) begin
            prio_d = 1'(PORT_HOST);
        end else if (grant[PORT_HOST]) begin
            prio_d = 1'(PORT_DRAW);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= 1'(PORT_DRAW);
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/fb_write_ctrl.sv
// Frame-buffer write-port sequencer: arbitrates two pixel writers and runs a full-buffer clear.
module fb_write_ctrl
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CLEAR_LAST = 255
) (
    input  logic          clk,
    input  logic          reset,
    fb_write_ctrl_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CLEAR_LAST);

    fb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic       start_ok;
    logic       arb_en;
    logic [1:0] grant;

    assign start_ok = (state_q == ST_IDLE) && bus.clr_start;
    assign arb_en   = (state_q == ST_IDLE) && !bus.clr_start;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({bus.req1_valid, bus.req0_valid}),
        .enable (arb_en),
        .grant  (grant)
    );

    assign bus.req0_ready = grant[PORT_DRAW];
    assign bus.req1_ready = grant[PORT_HOST];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.clr_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        fill_d = fill_q;
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        // busy stays up for one idle cycle after the last clear write, then done pulses
        done_d = (state_q == ST_IDLE) && busy_q;
        busy_d = start_ok ? 1'b1 : (done_d ? 1'b0 : busy_q);
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    fill_d = bus.clr_value;
                    cnt_d  = '0;
                end else if (grant[PORT_DRAW]) begin
                    we_d   = 1'b1;
                    addr_d = bus.req0_addr;
                    data_d = bus.req0_data;
                end else if (grant[PORT_HOST]) begin
                    we_d   = 1'b1;
                    addr_d = bus.req1_addr;
                    data_d = bus.req1_data;
                end
            end
            ST_CLEAR: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = fill_q;
                cnt_d  = (cnt_q == LAST_ADDR) ? cnt_q : cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ram_we      = we_q;
    assign bus.ram_wr_addr = addr_q;
    assign bus.ram_wr_data = data_q;
    assign bus.clr_busy    = busy_q;
    assign bus.clr_done    = done_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Bench for fb_write_ctrl: cycle model of arbitration and clear, plus directed literal checks.
module tb_fb_write_ctrl;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int LAST = 255;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fb_write_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fb_write_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_LAST(LAST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: clearing flag with next address, tie preference, pending done pulse
    logic          m_clearing, m_pend, m_pref;
    int            m_addr;
    logic [DW-1:0] m_fill;
    logic          exp_we, exp_busy, exp_done;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          m_r0, m_r1;

    always @* begin
        m_r0 = !m_clearing && !bus.clr_start && bus.req0_valid &&
               (!bus.req1_valid || m_pref == 1'b0);
        m_r1 = !m_clearing && !bus.clr_start && bus.req1_valid &&
               (!bus.req0_valid || m_pref == 1'b1);
    end

    always @(posedge clk or posedge reset) begin
        logic g0, g1, st;
        if (reset) begin
            m_clearing = 0; m_pend = 0; m_pref = 0; m_addr = 0; m_fill = '0;
            exp_we = 0; exp_busy = 0; exp_done = 0; exp_addr = '0; exp_data = '0;
        end else begin
            g0 = m_r0; g1 = m_r1; st = bus.clr_start;
            exp_we = 0; exp_done = 0;
            if (m_clearing) begin
                exp_we = 1; exp_addr = AW'(m_addr); exp_data = m_fill;
                if (m_addr == LAST) begin
                    m_clearing = 0; m_pend = 1;
                end
                m_addr++;
            end else begin
                if (m_pend) begin
                    exp_done = 1; exp_busy = 0; m_pend = 0;
                end
                if (st) begin
                    m_clearing = 1; m_addr = 0; m_fill = bus.clr_value; exp_busy = 1;
                end else if (g0) begin
                    exp_we = 1; exp_addr = bus.req0_addr; exp_data = bus.req0_data; m_pref = 1;
                end else if (g1) begin
                    exp_we = 1; exp_addr = bus.req1_addr; exp_data = bus.req1_data; m_pref = 0;
                end
            end
        end
    end

    // Per-cycle comparison plus a RAM scoreboard and event counters
    logic [DW-1:0] ram [256];
    int clr_writes = 0, done_cnt = 0, r1_in_clear = 0;

    always @(negedge clk) begin
        if (!reset) begin
            check("ready0", bus.req0_ready, m_r0);
            check("ready1", bus.req1_ready, m_r1);
            check("ram_we", bus.ram_we, exp_we);
            check("clr_busy", bus.clr_busy, exp_busy);
            check("clr_done", bus.clr_done, exp_done);
            if (exp_we) begin
                check("ram_wr_addr", bus.ram_wr_addr, exp_addr);
                check("ram_wr_data", bus.ram_wr_data, exp_data);
            end
            if (bus.ram_we) ram[bus.ram_wr_addr] = bus.ram_wr_data;
            if (bus.ram_we && bus.clr_busy) clr_writes++;
            if (bus.clr_done) done_cnt++;
            if (bus.req1_ready && bus.clr_busy && !(bus.ram_we && bus.ram_wr_addr == AW'(LAST)))
                r1_in_clear++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int bound, output bit seen);
        seen = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.clr_done) begin
                seen = 1;
                break;
            end
        end
    endtask

    function automatic int ram_bad(input logic [DW-1:0] v);
        int n = 0;
        for (int a = 0; a <= LAST; a++) if (ram[a] !== v) n++;
        return n;
    endfunction

    initial begin
        int gseq[$];
        int snap_w, snap_d, snap_r;
        logic [AW-1:0] exp_a [4];
        logic [AW-1:0] a0, a1;
        bit seen;

        exp_a[0] = 8'h20; exp_a[1] = 8'h30; exp_a[2] = 8'h21; exp_a[3] = 8'h31;
        bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.clr_start = 0; bus.clr_value = '0;
        #1 reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_we", bus.ram_we, 1'b0);
        check("reset_addr", bus.ram_wr_addr, '0);
        check("reset_busy", bus.clr_busy, 1'b0);
        step();
        reset = 0;

        // Single write from port 0
        step();
        bus.req0_valid = 1; bus.req0_addr = 8'h10; bus.req0_data = 32'hDEADBEEF;
        @(negedge clk);
        check("single_ready0", bus.req0_ready, 1'b1);
        step();
        bus.req0_valid = 0;
        @(negedge clk);
        check("single_we", bus.ram_we, 1'b1);
        check("single_addr", bus.ram_wr_addr, 8'h10);
        check("single_data", bus.ram_wr_data, 32'hDEADBEEF);
        step();
        @(negedge clk);
        check("idle_we", bus.ram_we, 1'b0);
        check("idle_addr_hold", bus.ram_wr_addr, 8'h10);

        // Port-1 write so that port 0 is owed the next tie
        step();
        bus.req1_valid = 1; bus.req1_addr = 8'h05; bus.req1_data = 32'h5;
        step();
        bus.req1_valid = 0;

        // Contention for four cycles
        a0 = 8'h20; a1 = 8'h30;
        bus.req0_valid = 1; bus.req0_addr = a0; bus.req0_data = 32'hA000_0000 | 32'(a0);
        bus.req1_valid = 1; bus.req1_addr = a1; bus.req1_data = 32'hB000_0000 | 32'(a1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) check("contend_addr", bus.ram_wr_addr, exp_a[k-1]);
            gseq.push_back(bus.req0_ready ? 0 : (bus.req1_ready ? 1 : 2));
            step();
            if (gseq[k] == 0) a0++;
            if (gseq[k] == 1) a1++;
            bus.req0_addr = a0; bus.req0_data = 32'hA000_0000 | 32'(a0);
            bus.req1_addr = a1; bus.req1_data = 32'hB000_0000 | 32'(a1);
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(negedge clk);
        check("contend_addr", bus.ram_wr_addr, exp_a[3]);
        check("grant0", 64'(gseq[0]), 0);
        check("grant1", 64'(gseq[1]), 1);
        check("grant2", 64'(gseq[2]), 0);
        check("grant3", 64'(gseq[3]), 1);

        // Full clear
        snap_w = clr_writes; snap_d = done_cnt;
        step();
        bus.clr_start = 1; bus.clr_value = 32'h00FF00FF;
        step();
        bus.clr_start = 0; bus.clr_value = 32'h0;
        wait_done(400, seen);
        check("clear_done_seen", seen, 1'b1);
        repeat (3) step();
        check("clear_len", 64'(clr_writes - snap_w), 256);
        check("clear_done_pulses", 64'(done_cnt - snap_d), 1);
        check("clear_ram_bad", 64'(ram_bad(32'h00FF00FF)), 0);

        // Clear and port-1 request together, second start mid-clear
        snap_w = clr_writes; snap_r = r1_in_clear;
        step();
        bus.clr_start = 1; bus.clr_value = 32'h12345678;
        bus.req1_valid = 1; bus.req1_addr = 8'h77; bus.req1_data = 32'h0000A5A5;
        step();
        bus.clr_start = 0; bus.clr_value = 32'h0;
        repeat (50) step();
        bus.clr_start = 1; bus.clr_value = 32'h00000BAD;
        step();
        bus.clr_start = 0; bus.clr_value = 32'h0;
        wait_done(400, seen);
        check("sim_done_seen", seen, 1'b1);
        check("sim_req1_we", bus.ram_we, 1'b1);
        check("sim_req1_addr", bus.ram_wr_addr, 8'h77);
        check("sim_req1_data", bus.ram_wr_data, 32'h0000A5A5);
        step();
        bus.req1_valid = 0;
        repeat (2) step();
        check("sim_clear_len", 64'(clr_writes - snap_w), 256);
        check("sim_ready1_in_clear", 64'(r1_in_clear - snap_r), 0);
        ram[8'h77] = 32'h12345678;
        check("sim_ram_bad", 64'(ram_bad(32'h12345678)), 0);

        // Asynchronous reset mid-clear
        step();
        bus.clr_start = 1; bus.clr_value = 32'hCAFEF00D;
        step();
        bus.clr_start = 0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.ram_we && bus.ram_wr_addr == 8'd100) begin
                seen = 1;
                break;
            end
        end
        check("abort_addr100_seen", seen, 1'b1);
        snap_d = done_cnt;
        #1 reset = 1;
        #1;
        check("abort_we", bus.ram_we, 1'b0);
        check("abort_busy", bus.clr_busy, 1'b0);
        repeat (2) step();
        reset = 0;
        repeat (3) step();
        check("abort_no_done", 64'(done_cnt - snap_d), 0);
        bus.req0_valid = 1; bus.req0_addr = 8'h40; bus.req0_data = 32'h40;
        bus.req1_valid = 1; bus.req1_addr = 8'h41; bus.req1_data = 32'h41;
        @(negedge clk);
        check("post_reset_tie_r0", bus.req0_ready, 1'b1);
        check("post_reset_tie_r1", bus.req1_ready, 1'b0);
        step();
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(negedge clk);
        check("post_reset_addr", bus.ram_wr_addr, 8'h40);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_write_ctrl.md
Name: fb_write_ctrl

Overview:
Sequences the single write port of the frame-buffer RAM. Two pixel-write requesters (draw engine = port 0, host/config = port 1) share the port through round-robin arbitration with valid/ready handshakes. A built-in clear engine fills the whole buffer with a constant value. It sits between the drawing logic and the frame-buffer RAM. The RAM's asynchronous read port (display scan-out) is not touched by this block.

Parameters:
ADDR_WIDTH, 8, width of RAM write address
DATA_WIDTH, 32, width of RAM write data
CLEAR_LAST, 255, last address written by a clear; the clear covers 0..CLEAR_LAST, and CLEAR_LAST must be at most 2**ADDR_WIDTH-1

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  port 0 has a write pending
req0_addr  input  ADDR_WIDTH  port 0 write address
req0_data  input  DATA_WIDTH  port 0 write data
req0_ready  output  1  port 0 write accepted this cycle (combinational)
req1_valid  input  1  port 1 has a write pending
req1_addr  input  ADDR_WIDTH  port 1 write address
req1_data  input  DATA_WIDTH  port 1 write data
req1_ready  output  1  port 1 write accepted this cycle (combinational)
clr_start  input  1  one-cycle pulse that starts a clear
clr_value  input  DATA_WIDTH  fill value, sampled when clr_start is accepted
clr_busy  output  1  clear in progress
clr_done  output  1  one-cycle pulse when a clear completes
ram_we  output  1  RAM write enable (registered)
ram_wr_addr  output  ADDR_WIDTH  RAM write address (registered)
ram_wr_data  output  DATA_WIDTH  RAM write data (registered)

Behaviour:
- Reset values: ram_we=0, ram_wr_addr=0, ram_wr_data=0, clr_busy=0, clr_done=0.
- Reset state: FSM=IDLE, round-robin pointer favours port 0, clear counter=0, latched fill value=0.
- FSM states are IDLE and CLEAR.
- IDLE, clr_start=1:
  - latch clr_value and set counter=0;
  - go to CLEAR;
  - both ready outputs stay 0 in that cycle, so clear beats any simultaneous request.
- IDLE, no clr_start:
  - a transfer occurs when reqN_valid && reqN_ready at a rising edge;
  - only port 0 valid: grant port 0. Only port 1 valid: grant port 1;
  - both valid: grant the port not granted most recently; after reset, port 0 wins the first tie;
  - the pointer updates only on an actual transfer;
  - at most one ready is high per cycle, and ready never goes high without the matching valid.
- Write latency: a transfer at edge N drives ram_we=1 with the granted addr/data on the registered outputs from edge N to edge N+1. The RAM commits the write at edge N+1.
- Back-to-back: one transfer per cycle sustained; the same port may transfer every cycle if the other port is idle.
- Any cycle with no transfer and no clear write: ram_we=0, and addr/data hold their last values.
- CLEAR:
  - each cycle drives ram_we=1, ram_wr_addr=counter, ram_wr_data=latched value;
  - counter increments by 1, with no wrap past CLEAR_LAST;
  - both ready outputs are 0;
  - clr_busy=1 from the edge that enters CLEAR through the edge that issues the CLEAR_LAST write.
- CLEAR termination: the edge issuing address CLEAR_LAST returns the FSM to IDLE. On the following edge, clr_busy=0 and clr_done=1 for exactly one cycle; port grants may resume in that same cycle.
- A clear therefore takes CLEAR_LAST+1 write cycles.
- clr_start while in CLEAR is ignored: no restart, and the latched value is unchanged.
- clr_value changing during CLEAR has no effect.
- Reset mid-clear: abort immediately to reset values, no clr_done pulse. A partial clear is left in the RAM.
- Requester rule: addr/data must stay stable while valid=1 and ready=0. The block does not check this.

Decomposition:
- Shared package (fb_pkg): FSM state encoding constants (ST_IDLE, ST_CLEAR) and port-index constants (PORT_DRAW=0, PORT_HOST=1), reused by later frame-buffer blocks.
- One natural sub-module, rr_arb2: a two-requester round-robin arbiter. Inputs: clk, reset, req[1:0], enable (=IDLE && !clr_start). Output: one-hot grant[1:0]; internal pointer updates on grant.
- Everything else (FSM, clear counter, output registers) lives in fb_write_ctrl.

Test Plan:
- Reset then single writes: req0 addr=0x10 data=0xDEADBEEF.
  - Expected: ready0=1 in the same cycle; next cycle ram_we=1, ram_wr_addr=0x10, ram_wr_data=0xDEADBEEF.
  - Then: ram_we=0 when no valid.
- Contention: both valid for 4 consecutive cycles, each presenting new addr/data after every accept.
  - Expected: grants 0,1,0,1; one ram_we per cycle; addresses match the granted ports in that order.
- Clear, CLEAR_LAST=255, clr_value=0x00FF00FF.
  - Expected: 256 consecutive ram_we cycles with addresses 0..255 and data 0x00FF00FF; clr_busy high for those cycles; clr_done high for exactly 1 cycle afterwards.
  - Scoreboard check: a RAM model holds 0x00FF00FF at every address.
- Simultaneous events in IDLE: clr_start and req1_valid together.
  - Expected: ready1=0 throughout the clear; req1's write issues on the cycle clr_done is high.
  - Also: a second clr_start mid-clear is ignored, and the clear length is still 256.
- Reset asserted asynchronously at clear address 100.
  - Expected: ram_we and clr_busy drop to 0 without waiting for clk; no clr_done pulse.
  - After release: a port-0/port-1 tie grants port 0 first.
